// File: rtl/max_scan_engine_if.sv
// ---------------------------------------------------------------------------
// max_scan_engine_if
// Bundles the control handshake and data-memory bus of max_scan_engine.
//   start    : scan request from the host
//   len      : element count, taken when a start is accepted
//   busy     : scan in progress (accepted start up to the end of the done cycle)
//   done     : one-cycle completion pulse
//   adr      : word-aligned byte address to data memory
//   d_in     : write data to data memory
//   MemRead  : memory read enable
//   MemWrite : memory write enable (memory commits on rising clk)
//   d_out    : memory read data, combinational from adr
// Modports:
//   master : the scan engine (drives the memory bus, answers the handshake)
//   slave  : the environment (host plus data memory)
// ---------------------------------------------------------------------------
interface max_scan_engine_if;
  logic        start;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic [31:0] adr;
  logic [31:0] d_in;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] d_out;

  modport master (
    input  start, len, d_out,
    output busy, done, adr, d_in, MemRead, MemWrite
  );

  modport slave (
    output start, len, d_out,
    input  busy, done, adr, d_in, MemRead, MemWrite
  );
endinterface

// File: rtl/max_scan_engine.sv
// ---------------------------------------------------------------------------
// max_scan_engine
// Scans len 32-bit words starting at byte address BASE_ADR, finds the largest
// value (lowest index wins ties) and writes the value to RES_ADR and the
// 0-based index to RES_ADR+4, then pulses done for one cycle.
// An empty scan (len=0) writes value 0 and index 32'hFFFF_FFFF without
// reading memory.
//
// Parameters:
//   BASE_ADR : byte address of element 0
//   RES_ADR  : byte address of the result pair
// Ports:
//   clk : clock, all state changes on rising edge
//   rst : asynchronous active-high reset
//   bus : max_scan_engine_if.master (handshake + data-memory bus)
//
// Configuration macro:
//   MAX_SCAN_SIGNED_EN : defined -> elements compared as two's-complement
//                        signed; undefined (default) -> unsigned compare.
//
// All bus outputs are decoded only from the state, counter and best-value
// flops, so they never depend combinationally on d_out or start.
// ---------------------------------------------------------------------------
module max_scan_engine #(
  parameter logic [31:0] BASE_ADR = 32'd1000,
  parameter logic [31:0] RES_ADR  = 32'd2000
) (
  input  logic              clk,
  input  logic              rst,
  max_scan_engine_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WR_VAL = 3'd2,
    ST_WR_IDX = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  state_e      state_q;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  logic [31:0] best_val_q;
  logic [15:0] best_idx_q;

  logic        take_s;
  logic        last_s;

  // True when cand must replace the current best (strictly greater only).
  function automatic logic beats(input logic [31:0] cand, input logic [31:0] best);
`ifdef MAX_SCAN_SIGNED_EN
    beats = ($signed(cand) > $signed(best));
`else
    beats = (cand > best);
`endif
  endfunction

  // Element 0 always seeds the best registers; later elements must beat them.
  always_comb begin
    take_s = 1'b0;
    last_s = 1'b0;
    if (idx_q == 16'd0) begin
      take_s = 1'b1;
    end else begin
      take_s = beats(bus.d_out, best_val_q);
    end
    // len_q is never 0 while in READ, so len_q-1 cannot underflow there.
    last_s = (idx_q == (len_q - 16'd1));
  end

  // Scan FSM: state, element counter, latched length and best registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= 16'd0;
      idx_q      <= 16'd0;
      best_val_q <= 32'd0;
      best_idx_q <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            len_q      <= bus.len;
            idx_q      <= 16'd0;
            best_val_q <= 32'd0;
            best_idx_q <= 16'd0;
            state_q    <= (bus.len == 16'd0) ? ST_WR_VAL : ST_READ;
          end
        end
        ST_READ: begin
          if (take_s) begin
            best_val_q <= bus.d_out;
            best_idx_q <= idx_q;
          end
          idx_q <= idx_q + 16'd1;
          if (last_s) begin
            state_q <= ST_WR_VAL;
          end
        end
        ST_WR_VAL: state_q <= ST_WR_IDX;
        ST_WR_IDX: state_q <= ST_DONE;
        ST_DONE:   state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Bus decode from state; IDLE and DONE keep the memory bus fully quiet.
  always_comb begin
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.adr      = 32'd0;
    bus.d_in     = 32'd0;
    case (state_q)
      ST_IDLE: begin
        bus.busy = 1'b0;
      end
      ST_READ: begin
        bus.busy    = 1'b1;
        bus.MemRead = 1'b1;
        bus.adr     = BASE_ADR + {14'd0, idx_q, 2'b00};
      end
      ST_WR_VAL: begin
        bus.busy     = 1'b1;
        bus.MemWrite = 1'b1;
        bus.adr      = RES_ADR;
        bus.d_in     = best_val_q;
      end
      ST_WR_IDX: begin
        bus.busy     = 1'b1;
        bus.MemWrite = 1'b1;
        bus.adr      = RES_ADR + 32'd4;
        // An empty scan reports "no index" as all ones.
        if (len_q == 16'd0) begin
          bus.d_in = 32'hFFFF_FFFF;
        end else begin
          bus.d_in = {16'd0, best_idx_q};
        end
      end
      ST_DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule
